// File: rtl/operand_collector_pkg.sv
// Shared constants and types for the operand collector: sizing of the
// collector, the per-entry record and a small index helper.
package oc_pkg;

    localparam int NUM_ENTRIES = 4;
    localparam int DATA_W      = 256;
    localparam int INFO_W      = 32;
    localparam int NUM_BANKS   = 4;
    localparam int ENTRY_W     = 2;

    typedef logic [ENTRY_W-1:0] entry_idx_t;
    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [INFO_W-1:0]  info_t;

    // One collector slot: an allocated instruction waiting for its operands.
    typedef struct packed {
        logic  valid;
        logic  s1_rdy;
        logic  s2_rdy;
        info_t info;
        data_t s1_data;
        data_t s2_data;
    } oc_entry_t;

    // Next entry index in round-robin order; wraps naturally at NUM_ENTRIES.
    function automatic entry_idx_t rr_next(input entry_idx_t idx);
        return idx + entry_idx_t'(1);
    endfunction

endpackage

// File: rtl/operand_collector_if.sv
// Bus bundle around the operand collector: RAU allocation, the four RF bank
// returns and the issue handshake toward the execution stage.
interface operand_collector_if;
    import oc_pkg::*;

    // RAU allocation side
    logic                 RAU_Alloc;
    info_t                RAU_Instr_Info;
    logic                 RAU_Src1_Needed;
    logic                 RAU_Src2_Needed;
    entry_idx_t           OC_Free_EntryNum;
    logic                 OC_Full;

    // Register-file bank returns
    data_t                RF_Out_Bank0;
    data_t                RF_Out_Bank1;
    data_t                RF_Out_Bank2;
    data_t                RF_Out_Bank3;
    entry_idx_t           RF_Bank0_EntryNum_OC;
    entry_idx_t           RF_Bank1_EntryNum_OC;
    entry_idx_t           RF_Bank2_EntryNum_OC;
    entry_idx_t           RF_Bank3_EntryNum_OC;
    logic [NUM_BANKS-1:0] RF_Dout_Valid;
    logic [NUM_BANKS-1:0] RF_SrcNum_OC;

    // Issue handshake
    logic                 OC_Issue_Valid;
    logic                 EX_Ready;
    entry_idx_t           OC_Issue_EntryNum;
    info_t                OC_Issue_Info;
    data_t                OC_Issue_Src1_Data;
    data_t                OC_Issue_Src2_Data;

    // Environment side: RAU, register file and execution stage.
    modport master (
        output RAU_Alloc, RAU_Instr_Info, RAU_Src1_Needed, RAU_Src2_Needed,
        input  OC_Free_EntryNum, OC_Full,
        output RF_Out_Bank0, RF_Out_Bank1, RF_Out_Bank2, RF_Out_Bank3,
        output RF_Bank0_EntryNum_OC, RF_Bank1_EntryNum_OC,
        output RF_Bank2_EntryNum_OC, RF_Bank3_EntryNum_OC,
        output RF_Dout_Valid, RF_SrcNum_OC,
        input  OC_Issue_Valid, OC_Issue_EntryNum, OC_Issue_Info,
        input  OC_Issue_Src1_Data, OC_Issue_Src2_Data,
        output EX_Ready
    );

    // Collector side.
    modport slave (
        input  RAU_Alloc, RAU_Instr_Info, RAU_Src1_Needed, RAU_Src2_Needed,
        output OC_Free_EntryNum, OC_Full,
        input  RF_Out_Bank0, RF_Out_Bank1, RF_Out_Bank2, RF_Out_Bank3,
        input  RF_Bank0_EntryNum_OC, RF_Bank1_EntryNum_OC,
        input  RF_Bank2_EntryNum_OC, RF_Bank3_EntryNum_OC,
        input  RF_Dout_Valid, RF_SrcNum_OC,
        output OC_Issue_Valid, OC_Issue_EntryNum, OC_Issue_Info,
        output OC_Issue_Src1_Data, OC_Issue_Src2_Data,
        input  EX_Ready
    );

endinterface

// File: rtl/operand_collector_rr_arbiter.sv
// 4-way round-robin arbiter: grants the first requesting entry found when
// scanning upward (with wrap) from the pointer.
module oc_rr_arbiter
    import oc_pkg::*;
(
    input  logic [NUM_ENTRIES-1:0] req,
    input  entry_idx_t             ptr,
    output entry_idx_t             grant,
    output logic                   any_grant
);

    entry_idx_t idx;

    // Scan from the pointer and keep the first hit.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant     = ptr;
        any_grant = 1'b0;
        idx       = ptr;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            idx = ptr + entry_idx_t'(k);
            if (!any_grant && req[idx]) begin
                grant     = idx;
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_collector.sv
// Operand collector: holds up to four allocated instructions, gathers their
// two source operands from the RF bank returns and issues complete
// instructions over a valid/ready handshake.
module operand_collector
    import oc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    operand_collector_if.slave  bus
);

    oc_entry_t            entry_q [NUM_ENTRIES];
    oc_entry_t            entry_d [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] valid_vec;
    logic [NUM_ENTRIES-1:0] elig_vec;
    entry_idx_t           free_idx;
    logic                 free_found;
    logic                 full;

    data_t                bank_data  [NUM_BANKS];
    entry_idx_t           bank_entry [NUM_BANKS];
    entry_idx_t           tgt;
    logic                 bank_collision;

    entry_idx_t           rr_ptr_q;
    entry_idx_t           grant_idx;
    logic                 any_grant;
    logic                 issue_load;
    logic                 issue_fire;
    logic                 alloc_fire;

    logic                 issue_valid_q;
    entry_idx_t           issue_entry_q;
    info_t                issue_info_q;
    data_t                issue_s1_q;
    data_t                issue_s2_q;

    assign bank_data[0]  = bus.RF_Out_Bank0;
    assign bank_data[1]  = bus.RF_Out_Bank1;
    assign bank_data[2]  = bus.RF_Out_Bank2;
    assign bank_data[3]  = bus.RF_Out_Bank3;
    assign bank_entry[0] = bus.RF_Bank0_EntryNum_OC;
    assign bank_entry[1] = bus.RF_Bank1_EntryNum_OC;
    assign bank_entry[2] = bus.RF_Bank2_EntryNum_OC;
    assign bank_entry[3] = bus.RF_Bank3_EntryNum_OC;

    // Occupancy and eligibility, from registered entry state only.
    always_comb begin
        valid_vec = '0;
        elig_vec  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            valid_vec[i] = entry_q[i].valid;
            elig_vec[i]  = entry_q[i].valid && entry_q[i].s1_rdy && entry_q[i].s2_rdy;
        end
    end

    // Lowest-index free entry; reads 0 when the collector is full.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!free_found && !valid_vec[i]) begin
                free_idx   = entry_idx_t'(i);
                free_found = 1'b1;
            end
        end
    end

    assign full = &valid_vec;

    oc_rr_arbiter u_arb (
        .req       (elig_vec),
        .ptr       (rr_ptr_q),
        .grant     (grant_idx),
        .any_grant (any_grant)
    );

    assign issue_load = !issue_valid_q || bus.EX_Ready;
    assign issue_fire = issue_load && any_grant;
    assign alloc_fire = bus.RAU_Alloc && !full;

    // Next entry state: bank captures, then issue invalidation, then allocation.
    always_comb begin
        entry_d = entry_q;
        tgt     = '0;
        // Walk banks high to low so the lowest bank's write lands last and wins.
        for (int b = NUM_BANKS - 1; b >= 0; b--) begin
            tgt = bank_entry[b];
            if (bus.RF_Dout_Valid[b] && entry_q[tgt].valid) begin
                if (!bus.RF_SrcNum_OC[b]) begin
                    if (!entry_q[tgt].s1_rdy) begin
                        entry_d[tgt].s1_data = bank_data[b];
                        entry_d[tgt].s1_rdy  = 1'b1;
                    end
                end else begin
                    if (!entry_q[tgt].s2_rdy) begin
                        entry_d[tgt].s2_data = bank_data[b];
                        entry_d[tgt].s2_rdy  = 1'b1;
                    end
                end
            end
        end
        if (issue_fire) begin
            entry_d[grant_idx].valid  = 1'b0;
            entry_d[grant_idx].s1_rdy = 1'b0;
            entry_d[grant_idx].s2_rdy = 1'b0;
        end
        // Allocation always targets an invalid entry, so it never collides with
        // the issued entry and overrides any (dropped) capture to the same slot.
        if (alloc_fire) begin
            entry_d[free_idx].valid   = 1'b1;
            entry_d[free_idx].s1_rdy  = !bus.RAU_Src1_Needed;
            entry_d[free_idx].s2_rdy  = !bus.RAU_Src2_Needed;
            entry_d[free_idx].info    = bus.RAU_Instr_Info;
            entry_d[free_idx].s1_data = '0;
            entry_d[free_idx].s2_data = '0;
        end
    end

    // Entry storage: control bits reset, operand/payload storage does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
                entry_q[i].valid  <= 1'b0;
                entry_q[i].s1_rdy <= 1'b0;
                entry_q[i].s2_rdy <= 1'b0;
                // NOTE: operand/info payload is left unreset; it is only read behind valid and rewritten on allocation.
            end
        end else begin
            entry_q <= entry_d;
        end
    end

    // Issue register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_q <= 1'b0;
            issue_entry_q <= '0;
            issue_info_q  <= '0;
            issue_s1_q    <= '0;
            issue_s2_q    <= '0;
            rr_ptr_q      <= '0;
        end else if (issue_load) begin
            issue_valid_q <= any_grant;
            if (any_grant) begin
                issue_entry_q <= grant_idx;
                issue_info_q  <= entry_q[grant_idx].info;
                issue_s1_q    <= entry_q[grant_idx].s1_data;
                issue_s2_q    <= entry_q[grant_idx].s2_data;
                rr_ptr_q      <= rr_next(grant_idx);
            end
        end
    end

    // Two banks aiming at the same entry/source in one cycle is a protocol error.
    always_comb begin
        bank_collision = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int c = b + 1; c < NUM_BANKS; c++) begin
                if (bus.RF_Dout_Valid[b] && bus.RF_Dout_Valid[c] &&
                    (bank_entry[b] == bank_entry[c]) &&
                    (bus.RF_SrcNum_OC[b] == bus.RF_SrcNum_OC[c])) begin
                    bank_collision = 1'b1;
                end
            end
        end
    end

    a_no_bank_collision: assert property (@(posedge clk) disable iff (rst) !bank_collision);

    assign bus.OC_Free_EntryNum   = free_idx;
    assign bus.OC_Full            = full;
    assign bus.OC_Issue_Valid     = issue_valid_q;
    assign bus.OC_Issue_EntryNum  = issue_entry_q;
    assign bus.OC_Issue_Info      = issue_info_q;
    assign bus.OC_Issue_Src1_Data = issue_s1_q;
    assign bus.OC_Issue_Src2_Data = issue_s2_q;

endmodule
